// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with internal baud divider; tx/txBusy/txDone are registered, frame starts one cycle after acceptance.
// Requests arriving while busy are dropped (no queuing); txEn low aborts the current frame.
module uart_transmitter #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in_data,
  output logic       tx,
  output logic       txBusy,
  output logic       txDone
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  always_comb begin
    bit_end = (cnt_q == CNT_LAST);
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // tx_d is the level for the state being entered, so tx stays a pure register
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (txStart) begin
          shift_d = in_data;
          idx_d   = 3'd0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Dropping txEn behaves exactly like reset: the frame is abandoned, not paused
  always_ff @(posedge clk) begin
    if (!rst_n || !txEn) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx     = tx_q;
  assign txBusy = busy_q;
  assign txDone = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at 16 clocks per bit: per-cycle waveform vectors plus a
// mid-bit sampling receiver whose decoded bytes are scored against a queue of sent bytes.
module tb_uart_transmitter;

  localparam int BC        = 16;
  localparam int FRAME_CYC = 10 * BC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       txEn;
  logic       txStart;
  logic [7:0] in_data;
  logic       tx;
  logic       txBusy;
  logic       txDone;

  uart_transmitter #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .txEn    (txEn),
    .txStart (txStart),
    .in_data (in_data),
    .tx      (tx),
    .txBusy  (txBusy),
    .txDone  (txDone)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         errors    = 0;
  int         done_cnt  = 0;
  int         rx_frames = 0;
  logic [7:0] sb[$];

  // frame bit i is the line level during bit slot i (0 = start, 1..8 = data LSB first, 9 = stop)
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_tx"}, tx, 1);
    chk({name, "_busy"}, txBusy, 0);
    chk({name, "_done"}, txDone, 0);
  endtask

  // Called right after the acceptance edge; checks cycles T+1 .. T+161
  task automatic run_frame(input logic [9:0] frame, input int pulse_at,
                           input int hold_at, input int abort_at);
    bit aborted;
    aborted = 0;
    for (int c = 1; c <= FRAME_CYC + 1; c++) begin
      @(negedge clk);
      if (aborted) begin
        chk_idle("abort");
      end else if (c <= FRAME_CYC) begin
        chk("frame_tx", tx, frame[(c - 1) / BC]);
        chk("frame_busy", txBusy, 1);
        chk("frame_done", txDone, 0);
      end else begin
        chk("end_tx", tx, 1);
        chk("end_busy", txBusy, 0);
        chk("end_done", txDone, 1);
      end
      if (c == 1) begin
        txStart = 1'b0;
        in_data = 8'($urandom);
      end
      if (pulse_at != 0 && c == pulse_at) begin
        txStart = 1'b1;
        in_data = 8'hFF;
      end
      if (pulse_at != 0 && c == pulse_at + 1) txStart = 1'b0;
      if (hold_at != 0 && c == hold_at) begin
        txStart = 1'b1;
        in_data = 8'h3C;
      end
      if (aborted && c == abort_at + 1) txStart = 1'b0;
      if (abort_at != 0 && c == abort_at) begin
        txEn    = 1'b0;
        txStart = 1'b1;
        aborted = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (txDone === 1'b1) done_cnt++;
    end
  end

  // Reference receiver: samples mid-bit, resets while txEn is low
  initial begin
    int         n;
    int         k;
    bit         act;
    logic [7:0] sh;
    act = 0;
    n   = 0;
    sh  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || txEn !== 1'b1) begin
        act = 0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1;
          n   = 1;
        end
      end else begin
        n++;
        if (n == BC / 2 && tx !== 1'b0) begin
          act = 0;
        end else if (n > BC / 2 && (n - BC / 2) % BC == 0) begin
          k = (n - BC / 2) / BC;
          if (k <= 8) begin
            sh[k-1] = tx;
          end else begin
            act = 0;
            chk("rx_stop", tx, 1);
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rx_unexpected: got byte %0h expected no frame at %0t", sh, $time);
            end else begin
              chk("rx_byte", sh, sb.pop_front());
            end
            rx_frames++;
          end
        end
      end
    end
  end

  initial begin
    vecs[0] = '{data: 8'h55, frame: 10'h2AA};
    vecs[1] = '{data: 8'h01, frame: 10'h202};
    vecs[2] = '{data: 8'h00, frame: 10'h200};
    vecs[3] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[4] = '{data: 8'h5A, frame: 10'h2B4};

    rst_n   = 1'b0;
    txEn    = 1'b1;
    txStart = 1'b1;
    in_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("reset");
    end
    txStart = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk_idle("post_reset");
    end

    for (int i = 0; i < 5; i++) begin
      in_data = vecs[i].data;
      txStart = 1'b1;
      @(posedge clk);
      sb.push_back(vecs[i].data);
      run_frame(vecs[i].frame, 0, 0, 0);
    end

    // busy rejection of 0xFF, then 0x3C held and accepted in the txDone cycle
    in_data = 8'hA3;
    txStart = 1'b1;
    @(posedge clk);
    sb.push_back(8'hA3);
    run_frame(10'h346, 50, 150, 0);
    sb.push_back(8'h3C);
    @(posedge clk);
    run_frame(10'h278, 0, 0, 0);

    // abort during data bit 4, with a coincident start request that must lose
    in_data = 8'h00;
    txStart = 1'b1;
    @(posedge clk);
    run_frame(10'h200, 0, 0, 1 + 5 * BC + 4);
    txEn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle("rearm");
    end

    in_data = 8'h81;
    txStart = 1'b1;
    @(posedge clk);
    sb.push_back(8'h81);
    run_frame(10'h302, 0, 0, 0);

    repeat (20) @(negedge clk);
    chk("done_count", done_cnt, 8);
    chk("rx_frames", rx_frames, 8);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
